// File: rtl/vta_mem_dpi_initiator.sv
// Requester-side burst initiator for the simulation DPI memory port: one AR/AW request per
// command, write beats streamed out, read beats collected into a one-entry output buffer.
module vta_mem_dpi_initiator #(
   parameter int unsigned LEN_BITS  = 8,
   parameter int unsigned ADDR_BITS = 64,
   parameter int unsigned DATA_BITS = 64,
   parameter int unsigned STRB_BITS = DATA_BITS / 8,
   parameter int unsigned TIMEOUT   = 1024
) (
   input  logic                 clock,
   input  logic                 reset,

   input  logic                 cmd_valid,
   output logic                 cmd_ready,
   input  logic                 cmd_write,
   input  logic [ADDR_BITS-1:0] cmd_addr,
   input  logic [LEN_BITS-1:0]  cmd_len,
   input  logic [LEN_BITS-1:0]  cmd_id,

   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATA_BITS-1:0] in_data,
   input  logic [STRB_BITS-1:0] in_strb,

   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATA_BITS-1:0] out_data,
   output logic                 out_last,

   output logic                 done,
   output logic                 err_id,
   output logic                 err_timeout,

   output logic                 dpi_req_ar_valid,
   output logic [LEN_BITS-1:0]  dpi_req_ar_len,
   output logic [LEN_BITS-1:0]  dpi_req_ar_id,
   output logic [ADDR_BITS-1:0] dpi_req_ar_addr,
   output logic                 dpi_req_aw_valid,
   output logic [LEN_BITS-1:0]  dpi_req_aw_len,
   output logic [ADDR_BITS-1:0] dpi_req_aw_addr,
   output logic                 dpi_wr_valid,
   output logic [DATA_BITS-1:0] dpi_wr_bits_data,
   output logic [STRB_BITS-1:0] dpi_wr_bits_strb,
   input  logic                 dpi_rd_valid,
   input  logic [LEN_BITS-1:0]  dpi_rd_bits_id,
   input  logic [DATA_BITS-1:0] dpi_rd_bits_data,
   output logic                 dpi_rd_ready
);

   localparam int unsigned WdBits = $clog2(TIMEOUT + 1);
   localparam logic [WdBits-1:0] WdLast = WdBits'(TIMEOUT - 1);

   typedef enum logic [2:0] {
      StIdle,
      StRdReq,
      StRdData,
      StWrReq,
      StWrData,
      StDone
   } state_e;

   state_e               state;
   logic [ADDR_BITS-1:0] addr_r;
   logic [LEN_BITS-1:0]  len_r;
   logic [LEN_BITS-1:0]  id_r;
   // One bit wider than len so a full 2^LEN_BITS burst never wraps.
   logic [LEN_BITS:0]    cnt;
   logic [WdBits-1:0]    wd;

   logic beats_left;
   logic last_beat;
   logic rd_acc;
   logic id_ok;
   logic out_take;
   logic in_acc;

   assign beats_left = cnt <= {1'b0, len_r};
   assign last_beat  = cnt == {1'b0, len_r};
   assign rd_acc     = dpi_rd_valid & dpi_rd_ready;
   assign id_ok      = dpi_rd_bits_id == id_r;
   assign out_take   = out_valid & out_ready;
   assign in_acc     = in_valid & in_ready;

   assign cmd_ready    = (state == StIdle) & ~reset;
   assign in_ready     = (state == StWrData) & beats_left;
   assign dpi_rd_ready = (state == StRdData) & (~out_valid | out_ready);

   // Request fields come straight from the captured command registers.
   assign dpi_req_ar_len  = len_r;
   assign dpi_req_ar_id   = id_r;
   assign dpi_req_ar_addr = addr_r;
   assign dpi_req_aw_len  = len_r;
   assign dpi_req_aw_addr = addr_r;

   always_ff @(posedge clock) begin
      if (reset) begin
         state            <= StIdle;
         addr_r           <= '0;
         len_r            <= '0;
         id_r             <= '0;
         cnt              <= '0;
         wd               <= '0;
         out_valid        <= 1'b0;
         out_data         <= '0;
         out_last         <= 1'b0;
         done             <= 1'b0;
         err_id           <= 1'b0;
         err_timeout      <= 1'b0;
         dpi_req_ar_valid <= 1'b0;
         dpi_req_aw_valid <= 1'b0;
         dpi_wr_valid     <= 1'b0;
         dpi_wr_bits_data <= '0;
         dpi_wr_bits_strb <= '0;
      end else begin
         dpi_req_ar_valid <= 1'b0;
         dpi_req_aw_valid <= 1'b0;
         dpi_wr_valid     <= 1'b0;
         done             <= 1'b0;

         unique case (state)
            StIdle: begin
               if (cmd_valid) begin
                  addr_r      <= cmd_addr;
                  len_r       <= cmd_len;
                  id_r        <= cmd_id;
                  cnt         <= '0;
                  wd          <= '0;
                  err_id      <= 1'b0;
                  err_timeout <= 1'b0;
                  if (cmd_write) begin
                     dpi_req_aw_valid <= 1'b1;
                     state            <= StWrReq;
                  end else begin
                     dpi_req_ar_valid <= 1'b1;
                     state            <= StRdReq;
                  end
               end
            end

            StRdReq: state <= StRdData;

            StWrReq: state <= StWrData;

            StWrData: begin
               if (in_acc) begin
                  dpi_wr_valid     <= 1'b1;
                  dpi_wr_bits_data <= in_data;
                  dpi_wr_bits_strb <= in_strb;
                  cnt              <= cnt + 1'b1;
                  if (last_beat) begin
                     state <= StDone;
                     done  <= 1'b1;
                  end
               end
            end

            StRdData: begin
               // A new matching beat replaces the buffer even while it is being drained.
               if (rd_acc && id_ok) begin
                  out_valid <= 1'b1;
                  out_data  <= dpi_rd_bits_data;
                  out_last  <= last_beat;
                  cnt       <= cnt + 1'b1;
               end else if (out_take) begin
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end

               if (rd_acc && !id_ok) begin
                  err_id <= 1'b1;
               end

               // Only starvation counts; a full buffer waiting on the consumer holds the count.
               if (rd_acc) begin
                  wd <= '0;
               end else if (!out_valid) begin
                  wd <= wd + 1'b1;
               end

               if (out_take && out_last) begin
                  state     <= StDone;
                  done      <= 1'b1;
                  out_valid <= 1'b0;
                  out_last  <= 1'b0;
               end else if (!rd_acc && !out_valid && wd == WdLast) begin
                  err_timeout <= 1'b1;
                  state       <= StDone;
                  done        <= 1'b1;
                  out_valid   <= 1'b0;
                  out_last    <= 1'b0;
               end
            end

            StDone: state <= StIdle;

            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_vta_mem_dpi_initiator.sv
// Directed bench for vta_mem_dpi_initiator: write burst, read bursts with backpressure,
// id mismatch, watchdog expiry, mid-burst reset and a full-length read burst.
module tb_vta_mem_dpi_initiator;

   localparam int unsigned LB = 8;
   localparam int unsigned AB = 64;
   localparam int unsigned DB = 64;
   localparam int unsigned SB = DB / 8;
   localparam int unsigned TO = 16;

   logic          clock;
   logic          reset;
   logic          cmd_valid;
   logic          cmd_ready;
   logic          cmd_write;
   logic [AB-1:0] cmd_addr;
   logic [LB-1:0] cmd_len;
   logic [LB-1:0] cmd_id;
   logic          in_valid;
   logic          in_ready;
   logic [DB-1:0] in_data;
   logic [SB-1:0] in_strb;
   logic          out_valid;
   logic          out_ready;
   logic [DB-1:0] out_data;
   logic          out_last;
   logic          done;
   logic          err_id;
   logic          err_timeout;
   logic          dpi_req_ar_valid;
   logic [LB-1:0] dpi_req_ar_len;
   logic [LB-1:0] dpi_req_ar_id;
   logic [AB-1:0] dpi_req_ar_addr;
   logic          dpi_req_aw_valid;
   logic [LB-1:0] dpi_req_aw_len;
   logic [AB-1:0] dpi_req_aw_addr;
   logic          dpi_wr_valid;
   logic [DB-1:0] dpi_wr_bits_data;
   logic [SB-1:0] dpi_wr_bits_strb;
   logic          dpi_rd_valid;
   logic [LB-1:0] dpi_rd_bits_id;
   logic [DB-1:0] dpi_rd_bits_data;
   logic          dpi_rd_ready;

   vta_mem_dpi_initiator #(
      .LEN_BITS (LB),
      .ADDR_BITS(AB),
      .DATA_BITS(DB),
      .STRB_BITS(SB),
      .TIMEOUT  (TO)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .cmd_valid       (cmd_valid),
      .cmd_ready       (cmd_ready),
      .cmd_write       (cmd_write),
      .cmd_addr        (cmd_addr),
      .cmd_len         (cmd_len),
      .cmd_id          (cmd_id),
      .in_valid        (in_valid),
      .in_ready        (in_ready),
      .in_data         (in_data),
      .in_strb         (in_strb),
      .out_valid       (out_valid),
      .out_ready       (out_ready),
      .out_data        (out_data),
      .out_last        (out_last),
      .done            (done),
      .err_id          (err_id),
      .err_timeout     (err_timeout),
      .dpi_req_ar_valid(dpi_req_ar_valid),
      .dpi_req_ar_len  (dpi_req_ar_len),
      .dpi_req_ar_id   (dpi_req_ar_id),
      .dpi_req_ar_addr (dpi_req_ar_addr),
      .dpi_req_aw_valid(dpi_req_aw_valid),
      .dpi_req_aw_len  (dpi_req_aw_len),
      .dpi_req_aw_addr (dpi_req_aw_addr),
      .dpi_wr_valid    (dpi_wr_valid),
      .dpi_wr_bits_data(dpi_wr_bits_data),
      .dpi_wr_bits_strb(dpi_wr_bits_strb),
      .dpi_rd_valid    (dpi_rd_valid),
      .dpi_rd_bits_id  (dpi_rd_bits_id),
      .dpi_rd_bits_data(dpi_rd_bits_data),
      .dpi_rd_ready    (dpi_rd_ready)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #200000;
      $fatal(1, "FAIL global_timeout observed=running expected=finished");
   end

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int cmd_cyc = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int last_xfer_cyc = 0;
   int toggle_mode = 0;
   bit ready_phase = 1'b1;
   int rd_ready_violation = 0;
   int out_valid_seen = 0;
   int stall_cnt = 0;

   logic [DB-1:0] rd_data_q[$];
   logic [LB-1:0] rd_id_q[$];
   logic [DB-1:0] got_data[$];
   logic          got_last[$];
   logic [SB-1:0] wstrb[0:3];

   function automatic logic [63:0] pat(input logic [63:0] base, input int i);
      return base | 64'(i);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // One cycle: drive the memory model and consumer at negedge, then record what the next
   // posedge will transfer.
   task automatic tick();
      @(negedge clock);
      cyc++;
      if (rd_data_q.size() > 0) begin
         dpi_rd_valid     = 1'b1;
         dpi_rd_bits_id   = rd_id_q[0];
         dpi_rd_bits_data = rd_data_q[0];
      end else begin
         dpi_rd_valid     = 1'b0;
         dpi_rd_bits_id   = '0;
         dpi_rd_bits_data = '0;
      end
      out_ready   = (toggle_mode != 0) ? ready_phase : 1'b1;
      ready_phase = ~ready_phase;
      #1;
      if (out_valid) out_valid_seen++;
      if (out_valid && !out_ready) begin
         stall_cnt++;
         if (dpi_rd_ready) rd_ready_violation++;
      end
      if (out_valid && out_ready) begin
         got_data.push_back(out_data);
         got_last.push_back(out_last);
         if (out_last) last_xfer_cyc = cyc;
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (dpi_rd_valid && dpi_rd_ready) begin
         void'(rd_data_q.pop_front());
         void'(rd_id_q.pop_front());
      end
   endtask

   task automatic clear_mon();
      got_data.delete();
      got_last.delete();
      rd_ready_violation = 0;
      out_valid_seen     = 0;
      stall_cnt          = 0;
   endtask

   task automatic send_cmd(input logic wr, input logic [63:0] a, input logic [7:0] l,
                           input logic [7:0] id);
      cmd_valid = 1'b1;
      cmd_write = wr;
      cmd_addr  = a;
      cmd_len   = l;
      cmd_id    = id;
      #1;
      check("cmd_ready_idle", cmd_ready, 1);
      cmd_cyc = cyc;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic run_until_done(input string tag, input int budget);
      int start;
      int n;
      start = done_cnt;
      n = 0;
      while (done_cnt == start && n < budget) begin
         tick();
         n++;
      end
      check(tag, done_cnt - start, 1);
   endtask

   initial begin
      int dc;
      int lasts;
      reset = 1'b1;
      cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_id = '0;
      in_valid = 1'b0; in_data = '0; in_strb = '0;
      out_ready = 1'b1;
      dpi_rd_valid = 1'b0; dpi_rd_bits_id = '0; dpi_rd_bits_data = '0;
      wstrb[0] = 8'hFF; wstrb[1] = 8'h0F; wstrb[2] = 8'hF0; wstrb[3] = 8'h81;

      // Reset state
      tick();
      tick();
      check("rst_cmd_ready", cmd_ready, 0);
      check("rst_done", done, 0);
      check("rst_out_valid", out_valid, 0);
      check("rst_ar_valid", dpi_req_ar_valid, 0);
      check("rst_wr_valid", dpi_wr_valid, 0);
      reset = 1'b0;
      tick();
      check("post_rst_cmd_ready", cmd_ready, 1);
      check("post_rst_in_ready", in_ready, 0);
      check("post_rst_rd_ready", dpi_rd_ready, 0);

      // Write burst, 4 beats, in_valid held high
      send_cmd(1'b1, 64'h1000, 8'd3, 8'd0);
      check("wr_aw_valid", dpi_req_aw_valid, 1);
      check("wr_aw_len", dpi_req_aw_len, 3);
      check("wr_aw_addr", dpi_req_aw_addr, 64'h1000);
      check("wr_ar_quiet", dpi_req_ar_valid, 0);
      check("wr_cmd_ready_busy", cmd_ready, 0);
      in_valid = 1'b1;
      in_data  = pat(64'hCAFE_0000_0000_0000, 0);
      in_strb  = wstrb[0];
      tick();
      check("wr_aw_pulse_ends", dpi_req_aw_valid, 0);
      check("wr_in_ready", in_ready, 1);
      check("wr_no_early_beat", dpi_wr_valid, 0);
      for (int b = 0; b < 4; b++) begin
         in_data = pat(64'hCAFE_0000_0000_0000, b);
         in_strb = wstrb[b];
         tick();
         check("wr_beat_valid", dpi_wr_valid, 1);
         check("wr_beat_data", dpi_wr_bits_data, pat(64'hCAFE_0000_0000_0000, b));
         check("wr_beat_strb", dpi_wr_bits_strb, wstrb[b]);
         check("wr_done_timing", done, (b == 3) ? 1 : 0);
      end
      check("wr_in_ready_done", in_ready, 0);
      in_valid = 1'b0;
      tick();
      check("wr_done_pulse_ends", done, 0);
      check("wr_beats_end", dpi_wr_valid, 0);
      check("wr_cmd_ready_back", cmd_ready, 1);

      // Read, id 5, len 7, back-to-back beats, consumer always ready
      clear_mon();
      for (int i = 0; i < 8; i++) begin
         rd_data_q.push_back(pat(64'hD00D_0000_0000_0000, i));
         rd_id_q.push_back(8'd5);
      end
      send_cmd(1'b0, 64'h0000_0000_0004_0000, 8'd7, 8'd5);
      check("rd8_ar_valid", dpi_req_ar_valid, 1);
      check("rd8_ar_len", dpi_req_ar_len, 7);
      check("rd8_ar_id", dpi_req_ar_id, 5);
      check("rd8_ar_addr", dpi_req_ar_addr, 64'h0000_0000_0004_0000);
      check("rd8_rd_ready_in_req", dpi_rd_ready, 0);
      run_until_done("rd8_done_seen", 40);
      check("rd8_beats", got_data.size(), 8);
      for (int i = 0; i < 8; i++) begin
         if (i < got_data.size()) begin
            check("rd8_data", got_data[i], pat(64'hD00D_0000_0000_0000, i));
            check("rd8_last", got_last[i], (i == 7) ? 1 : 0);
         end
      end
      check("rd8_latency", done_cyc - cmd_cyc, 11);
      check("rd8_done_after_last", done_cyc - last_xfer_cyc, 1);
      check("rd8_rd_ready_done", dpi_rd_ready, 0);
      check("rd8_err_id", err_id, 0);
      check("rd8_err_timeout", err_timeout, 0);
      tick();
      check("rd8_idle", cmd_ready, 1);

      // Read len 3 with consumer toggling
      clear_mon();
      for (int i = 0; i < 4; i++) begin
         rd_data_q.push_back(pat(64'hBEEF_0000_0000_0000, i));
         rd_id_q.push_back(8'h11);
      end
      toggle_mode = 1;
      send_cmd(1'b0, 64'h3000, 8'd3, 8'h11);
      run_until_done("tog_done_seen", 40);
      toggle_mode = 0;
      check("tog_beats", got_data.size(), 4);
      for (int i = 0; i < 4; i++) begin
         if (i < got_data.size()) begin
            check("tog_data", got_data[i], pat(64'hBEEF_0000_0000_0000, i));
            check("tog_last", got_last[i], (i == 3) ? 1 : 0);
         end
      end
      check("tog_stalls_seen", stall_cnt > 0, 1);
      check("tog_rd_ready_when_full", rd_ready_violation, 0);
      check("tog_err_timeout", err_timeout, 0);
      tick();

      // Read id 2, len 1, stray id 3 beat between the good ones
      clear_mon();
      rd_data_q.push_back(64'hAAAA_0000_0000_0001); rd_id_q.push_back(8'd2);
      rd_data_q.push_back(64'h5555_0000_0000_0009); rd_id_q.push_back(8'd3);
      rd_data_q.push_back(64'hAAAA_0000_0000_0002); rd_id_q.push_back(8'd2);
      send_cmd(1'b0, 64'h4000, 8'd1, 8'd2);
      run_until_done("idm_done_seen", 40);
      check("idm_beats", got_data.size(), 2);
      if (got_data.size() == 2) begin
         check("idm_data0", got_data[0], 64'hAAAA_0000_0000_0001);
         check("idm_data1", got_data[1], 64'hAAAA_0000_0000_0002);
         check("idm_last0", got_last[0], 0);
         check("idm_last1", got_last[1], 1);
      end
      check("idm_err_id", err_id, 1);
      tick();
      check("idm_err_id_sticky", err_id, 1);

      // Read len 0, no response: watchdog expires after TO starved cycles
      clear_mon();
      send_cmd(1'b0, 64'h5000, 8'd0, 8'd7);
      check("to_err_id_cleared", err_id, 0);
      run_until_done("to_done_seen", 40);
      check("to_err_timeout", err_timeout, 1);
      check("to_latency", done_cyc - cmd_cyc, 18);
      check("to_no_out_valid", out_valid_seen, 0);
      check("to_err_id", err_id, 0);
      tick();
      check("to_err_timeout_sticky", err_timeout, 1);

      // Reset after 2 of 4 write beats
      clear_mon();
      send_cmd(1'b1, 64'h2000, 8'd3, 8'd0);
      check("rstw_err_timeout_cleared", err_timeout, 0);
      in_valid = 1'b1;
      tick();
      for (int b = 0; b < 2; b++) begin
         in_data = pat(64'h7777_0000_0000_0000, b);
         in_strb = wstrb[b];
         tick();
      end
      check("rstw_second_beat", dpi_wr_bits_data, pat(64'h7777_0000_0000_0000, 1));
      dc = done_cnt;
      reset    = 1'b1;
      in_valid = 1'b0;
      tick();
      check("rstw_wr_valid", dpi_wr_valid, 0);
      check("rstw_wr_data", dpi_wr_bits_data, 0);
      check("rstw_aw_addr", dpi_req_aw_addr, 0);
      check("rstw_in_ready", in_ready, 0);
      check("rstw_done", done, 0);
      reset = 1'b0;
      tick();
      check("rstw_idle", cmd_ready, 1);
      check("rstw_no_done", done_cnt - dc, 0);
      rd_data_q.push_back(64'h0123_4567_89AB_CDEF); rd_id_q.push_back(8'd9);
      send_cmd(1'b0, 64'h6000, 8'd0, 8'd9);
      check("rstw_ar_valid", dpi_req_ar_valid, 1);
      check("rstw_ar_id", dpi_req_ar_id, 9);
      run_until_done("rstw_rd_done", 40);
      check("rstw_rd_beats", got_data.size(), 1);
      if (got_data.size() == 1) begin
         check("rstw_rd_data", got_data[0], 64'h0123_4567_89AB_CDEF);
         check("rstw_rd_last", got_last[0], 1);
      end
      tick();

      // Full-length read: len 255 gives 256 beats without counter wrap
      clear_mon();
      for (int i = 0; i < 256; i++) begin
         rd_data_q.push_back(pat(64'hF00D_0000_0000_0000, i));
         rd_id_q.push_back(8'd0);
      end
      send_cmd(1'b0, 64'h8000, 8'd255, 8'd0);
      run_until_done("max_done_seen", 300);
      check("max_beats", got_data.size(), 256);
      lasts = 0;
      foreach (got_last[i]) if (got_last[i]) lasts++;
      check("max_last_count", lasts, 1);
      if (got_data.size() == 256) begin
         check("max_first_data", got_data[0], pat(64'hF00D_0000_0000_0000, 0));
         check("max_final_data", got_data[255], pat(64'hF00D_0000_0000_0000, 255));
         check("max_final_last", got_last[255], 1);
      end
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/vta_mem_dpi_initiator.md
Name: vta_mem_dpi_initiator

Overview:
- Burst initiator that drives the simulation memory DPI port from the requester side.
- Takes one read or write command at a time and issues the single-cycle AR or AW request.
- Streams write beats (data and strobe) out, or collects read beats into a registered output stream with id checking.
- Sits between VTA load/store/fetch logic (or a test harness) and the DPI memory model in simulation builds.

Parameters:
LEN_BITS, 8, width of burst length and id fields; length encodes beats-1
ADDR_BITS, 64, byte address width
DATA_BITS, 64, data beat width; must be a multiple of 64
STRB_BITS, DATA_BITS/8, byte strobe width
TIMEOUT, 1024, read watchdog limit in cycles; must be at least 2

Ports:
clock  in  1  clock
reset  in  1  synchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_BITS  burst start address
cmd_len  in  LEN_BITS  beats-1
cmd_id  in  LEN_BITS  read transaction id
in_valid  in  1  write beat offered
in_ready  out  1  write beat accepted
in_data  in  DATA_BITS  write beat data
in_strb  in  STRB_BITS  write beat byte strobe
out_valid  out  1  read beat available
out_ready  in  1  consumer accepts read beat
out_data  out  DATA_BITS  read beat data
out_last  out  1  final beat of the burst
done  out  1  one-cycle burst-complete pulse
err_id  out  1  sticky: read beat arrived with wrong id
err_timeout  out  1  sticky: read watchdog expired
dpi_req_ar_valid / _len / _id / _addr  out  1/LEN/LEN/ADDR  read request
dpi_req_aw_valid / _len / _addr  out  1/LEN/ADDR  write request
dpi_wr_valid / _bits_data / _bits_strb  out  1/DATA/STRB  write beat
dpi_rd_valid / _bits_id / _bits_data  in  1/LEN/DATA  read beat
dpi_rd_ready  out  1  read beat accept

Behaviour:
- Reset: clock is clock; reset is reset, synchronous, active-high. All outputs are 0 and state is IDLE. A reset mid-burst abandons the burst silently: no done pulse, no error, buffer cleared.
- All dpi_req_* and dpi_wr_* outputs are registered. The DPI side has no backpressure on AR, AW or W: each valid is a one-cycle pulse and is always taken.
- States: IDLE, RD_REQ, RD_DATA, WR_REQ, WR_DATA, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, capture addr, len, id and write into registers, and clear err_id and err_timeout.
  - Go to WR_REQ if cmd_write=1, else RD_REQ.
- RD_REQ / WR_REQ (1 cycle each):
  - The matching *_valid is high for exactly this cycle, carrying the captured len, addr and (for reads) id.
  - Then go to RD_DATA / WR_DATA.
  - Accept at cycle T gives the request at T+1.
- WR_DATA:
  - in_ready=1 while beats remain.
  - A beat accepted at cycle t is presented on dpi_wr_* at t+1 for one cycle; dpi_wr_valid is low otherwise.
  - A beat counter counts 0..len. Acceptance of beat len gives DONE on the next cycle.
- RD_DATA:
  - One-entry output buffer holding out_valid, out_data and out_last.
  - dpi_rd_ready = !out_valid | out_ready, combinational, and only in RD_DATA.
  - Beat acceptance = dpi_rd_valid & dpi_rd_ready.
  - An accepted beat with the matching id loads the buffer; the beat counter increments and out_last is set when count==len.
  - An accepted beat with a mismatched id is discarded and not counted, and err_id is set.
  - Simultaneous out_ready and a new beat: the buffer is replaced in the same cycle, giving full throughput.
  - Go to DONE when the consumer takes the buffered beat with out_last=1.
- Watchdog:
  - Counts cycles in RD_DATA with no accepted beat while the buffer is empty; it resets on any accepted beat.
  - Stalls caused by the consumer do not count.
  - On reaching TIMEOUT: set err_timeout, drop any buffered beat (out_valid becomes 0), go to DONE.
- DONE (1 cycle): done=1, dpi_rd_ready=0, then IDLE. A new command is accepted on the cycle after DONE at the earliest.
- Length: cmd_len=0 means 1 beat; cmd_len=2^LEN_BITS-1 means 2^LEN_BITS beats. The counter is LEN_BITS+1 wide, so there is no wrap.

Test Plan:
- Write, addr 0x1000, len 3, in_valid held high -> AW pulse at T+1 with len 3 and addr 0x1000; 4 dpi_wr_valid pulses on consecutive cycles with matching data and strobe; done 1 cycle after the last; cmd_ready returns.
- Read, id 5, len 7, out_ready=1, model returns 8 beats id 5 back-to-back -> 8 out beats, out_last only on the 8th, done 1 cycle after, no errors.
- Read len 3 with out_ready toggling 1/0 each cycle -> dpi_rd_ready low whenever the buffer is full and out_ready=0; no beat lost or duplicated; data order preserved.
- Read id 2, len 1, model injects one beat with id 3 between correct beats -> err_id=1, exactly 2 out beats, done pulses; err_id clears on the next cmd accept.
- Read len 0 with TIMEOUT=16 and no response -> err_timeout at 16 idle cycles, done pulse, out_valid never asserted.
- Reset asserted mid-write (after 2 of 4 beats) -> next cycle all outputs 0, state IDLE, no done; a new read command is accepted normally.
